universal_shift_reg: RTL and testbench

//  Parametrised universal register, successor to the fixed 4-bit parallel-load register.

---
 rtl/universal_shift_reg.sv | 143 ++++++++++++++
 tb/tb_universal_shift_reg.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_reg.sv
// ---------------------------------------------------------------------------
// universal_shift_reg
//
// Purpose:
//   Parametrised universal register that can hold, shift right, shift left
//   or parallel-load. One block covers PIPO, SIPO, SISO and PISO use.
//   A shared shift counter tracks shifts since the last load, reset or word
//   boundary. A one-cycle word_done pulse is raised after every WIDTH-th
//   shift, so a serial link can frame deserialised words.
//
// Parameters:
//   WIDTH      register width in bits, must be at least 2
//   CW         derived width of shift_cnt, $clog2(WIDTH+1); not overridable
//
// Ports:
//   clk        rising-edge clock, single clock domain
//   rst_n      synchronous active-low reset; wins over en and mode
//   en         clock enable; 0 freezes pout and shift_cnt
//   mode       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   pin        parallel data, taken when mode = 11
//   sin_r      serial input for right shifts, enters at the MSB
//   sin_l      serial input for left shifts, enters at the LSB
//   rot        (only with USR_ROTATE_EN) 1 = rotate instead of shifting in
//   pout       registered parallel output
//   sout_r     pout[0], serial output for right shifts
//   sout_l     pout[WIDTH-1], serial output for left shifts
//   shift_cnt  shifts since the last load, reset or word boundary
//   word_done  registered one-cycle pulse after the WIDTH-th shift
//
// Configuration:
//   USR_ROTATE_EN  when defined, adds the rot input. With rot=1, shifts
//                  recirculate the bit that falls off the end. The serial
//                  inputs are then ignored. Counting is unchanged.
// ---------------------------------------------------------------------------
module universal_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pin,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    shift_cnt,
    output logic             word_done
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] r_pout;
    logic [CW-1:0]    r_shiftCnt;
    logic             r_wordDone;

    logic             w_rightIn;
    logic             w_leftIn;
    logic [WIDTH-1:0] w_shiftRight;
    logic [WIDTH-1:0] w_shiftLeft;
    logic             w_lastShift;
    mode_e            w_mode;

    assign w_mode = mode_e'(mode);

    // Pick the bit that enters the register on a shift. When rotation is
    // built in and requested, the bit leaving the opposite end is fed back.
    // Otherwise the matching serial input is used.
    always_comb begin
        w_rightIn = sin_r;
        w_leftIn  = sin_l;
`ifdef USR_ROTATE_EN
        if (rot) begin
            w_rightIn = r_pout[0];
            w_leftIn  = r_pout[WIDTH-1];
        end
`endif
    end

    // Candidate next values for each shift direction. A shift is flagged as
    // the last one of a word when the counter already shows WIDTH-1.
    assign w_shiftRight = {w_rightIn, r_pout[WIDTH-1:1]};
    assign w_shiftLeft  = {r_pout[WIDTH-2:0], w_leftIn};
    assign w_lastShift  = (r_shiftCnt == CW'(WIDTH - 1));

    // Main register update, in priority order: reset, then enable, then mode.
    // Both shift directions share one counter. A direction change mid-word
    // keeps the count. Hold and a low enable only pause it. When the WIDTH-th
    // shift lands, the counter wraps to zero and word_done is raised for
    // exactly one cycle, so continuous shifting frames words with no gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pout     <= '0;
            r_shiftCnt <= '0;
            r_wordDone <= 1'b0;
        end else if (!en) begin
            r_wordDone <= 1'b0;
        end else begin
            case (w_mode)
                MODE_HOLD: begin
                    r_wordDone <= 1'b0;
                end
                MODE_RIGHT, MODE_LEFT: begin
                    r_pout <= (w_mode == MODE_RIGHT) ? w_shiftRight : w_shiftLeft;
                    if (w_lastShift) begin
                        r_shiftCnt <= '0;
                        r_wordDone <= 1'b1;
                    end else begin
                        r_shiftCnt <= r_shiftCnt + CW'(1);
                        r_wordDone <= 1'b0;
                    end
                end
                MODE_LOAD: begin
                    r_pout     <= pin;
                    r_shiftCnt <= '0;
                    r_wordDone <= 1'b0;
                end
                default: begin
                    r_wordDone <= 1'b0;
                end
            endcase
        end
    end

    // The serial outputs tap the register directly, so they follow its
    // content with no extra delay.
    assign pout      = r_pout;
    assign sout_r    = r_pout[0];
    assign sout_l    = r_pout[WIDTH-1];
    assign shift_cnt = r_shiftCnt;
    assign word_done = r_wordDone;

endmodule

// File: tb/tb_universal_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_universal_shift_reg
//
// Bench for universal_shift_reg with WIDTH = 8.
//
// A behavioural model of the register is advanced once per driven cycle.
// Each cycle, the model's expected outputs are packed and pushed onto a
// queue. Each scenario task pops one entry per clock and compares it with
// the DUT outputs, sampled 1 ns after the rising edge. Some scenarios also
// check fixed known values, such as the result of the SIPO sequence.
// Define USR_ROTATE_EN for both the bench and the RTL to exercise rotation.
// ---------------------------------------------------------------------------
module tb_universal_shift_reg;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] pin;
    logic             sin_r;
    logic             sin_l;
    logic             rot;
    logic [WIDTH-1:0] pout;
    logic             sout_r;
    logic             sout_l;
    logic [CW-1:0]    shift_cnt;
    logic             word_done;

    // Model state.
    logic [WIDTH-1:0] mPout;
    logic [CW-1:0]    mCnt;
    logic             mWd;

    // Packed layout: {pout, shift_cnt, word_done, sout_r, sout_l}.
    logic [WIDTH+CW+2:0] sbQ[$];
    logic [WIDTH+CW+2:0] expVal;
    logic [WIDTH+CW+2:0] obsVal;

    int testsRun;
    int testsFailed;

    universal_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .pin       (pin),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
`ifdef USR_ROTATE_EN
        .rot       (rot),
`endif
        .pout      (pout),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and advance the model to match. The
    // model's prediction is queued, then the task waits until 1 ns past the
    // rising edge, when the DUT outputs are settled.
    task automatic applyStimulus(input logic iRstN, input logic iEn,
                                 input logic [1:0] iMode,
                                 input logic [WIDTH-1:0] iPin,
                                 input logic iSr, input logic iSl,
                                 input logic iRot);
        logic             useRot;
        logic [WIDTH-1:0] nextPout;
        rst_n = iRstN;
        en    = iEn;
        mode  = iMode;
        pin   = iPin;
        sin_r = iSr;
        sin_l = iSl;
        rot   = iRot;
`ifdef USR_ROTATE_EN
        useRot = iRot;
`else
        useRot = 1'b0;
`endif
        nextPout = mPout;
        if (!iRstN) begin
            mPout = '0;
            mCnt  = '0;
            mWd   = 1'b0;
        end else if (!iEn) begin
            mWd = 1'b0;
        end else begin
            case (iMode)
                2'b00: mWd = 1'b0;
                2'b11: begin
                    mPout = iPin;
                    mCnt  = '0;
                    mWd   = 1'b0;
                end
                default: begin
                    if (iMode == 2'b01)
                        nextPout = {useRot ? mPout[0] : iSr, mPout[WIDTH-1:1]};
                    else
                        nextPout = {mPout[WIDTH-2:0], useRot ? mPout[WIDTH-1] : iSl};
                    mPout = nextPout;
                    if (mCnt == 4'd7) begin
                        mCnt = '0;
                        mWd  = 1'b1;
                    end else begin
                        mCnt = mCnt + 4'd1;
                        mWd  = 1'b0;
                    end
                end
            endcase
        end
        sbQ.push_back({mPout, mCnt, mWd, mPout[0], mPout[WIDTH-1]});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b1, 2'b11, 8'hFF, 1'b1, 1'b1, 1'b0);
        expVal = sbQ.pop_front();
        obsVal = {pout, shift_cnt, word_done, sout_r, sout_l};
        testsRun++;
        if (obsVal !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL reset_scoreboard: got %h expected %h", obsVal, expVal);
        end
        testsRun++;
        if ({pout, shift_cnt, word_done} !== 13'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_zero: got pout=%h cnt=%0d wd=%b expected all zero",
                     pout, shift_cnt, word_done);
        end
    endtask

    task automatic test_load();
        applyStimulus(1'b1, 1'b1, 2'b11, 8'hB6, 1'b0, 1'b0, 1'b0);
        expVal = sbQ.pop_front();
        obsVal = {pout, shift_cnt, word_done, sout_r, sout_l};
        testsRun++;
        if (obsVal !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL load_scoreboard: got %h expected %h", obsVal, expVal);
        end
        testsRun++;
        if ({pout, sout_r, sout_l, shift_cnt} !== {8'hB6, 1'b0, 1'b1, 4'd0}) begin
            testsFailed++;
            $display("[TB] FAIL load_value: got pout=%h sr=%b sl=%b cnt=%0d expected B6 0 1 0",
                     pout, sout_r, sout_l, shift_cnt);
        end
    endtask

    task automatic test_sipo();
        logic [7:0] bits;
        bits = 8'b0100_1101;
        applyStimulus(1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 2'b01, 8'h00, bits[i], 1'b0, 1'b0);
            expVal = sbQ.pop_front();
            obsVal = {pout, shift_cnt, word_done, sout_r, sout_l};
            testsRun++;
            if (obsVal !== expVal) begin
                testsFailed++;
                $display("[TB] FAIL sipo_shift%0d: got %h expected %h", i, obsVal, expVal);
            end
        end
        testsRun++;
        if ({pout, word_done, shift_cnt} !== {8'h4D, 1'b1, 4'd0}) begin
            testsFailed++;
            $display("[TB] FAIL sipo_word: got pout=%h wd=%b cnt=%0d expected 4D 1 0",
                     pout, word_done, shift_cnt);
        end
        applyStimulus(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
        expVal = sbQ.pop_front();
        obsVal = {pout, shift_cnt, word_done, sout_r, sout_l};
        testsRun++;
        if (obsVal !== expVal || word_done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sipo_pulse_end: got %h expected %h", obsVal, expVal);
        end
    endtask

    task automatic test_pause_mix();
        logic [1:0] modeSeq [11];
        logic       enSeq   [11];
        modeSeq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                    2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        enSeq   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        applyStimulus(1'b1, 1'b1, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, enSeq[i], modeSeq[i], 8'hFF, i[0], ~i[0], 1'b0);
            expVal = sbQ.pop_front();
            obsVal = {pout, shift_cnt, word_done, sout_r, sout_l};
            testsRun++;
            if (obsVal !== expVal) begin
                testsFailed++;
                $display("[TB] FAIL pause_step%0d: got %h expected %h", i, obsVal, expVal);
            end
            if (i == 4) begin
                testsRun++;
                if (shift_cnt !== 4'd3) begin
                    testsFailed++;
                    $display("[TB] FAIL pause_count: got %0d expected 3", shift_cnt);
                end
            end
        end
        testsRun++;
        if (word_done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL pause_word_done: got %b expected 1", word_done);
        end
    endtask

    task automatic test_reset_midword();
        applyStimulus(1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        for (int i = 0; i < 14; i++) begin
            applyStimulus((i == 5) ? 1'b0 : 1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
            expVal = sbQ.pop_front();
            obsVal = {pout, shift_cnt, word_done, sout_r, sout_l};
            testsRun++;
            if (obsVal !== expVal) begin
                testsFailed++;
                $display("[TB] FAIL midreset_step%0d: got %h expected %h", i, obsVal, expVal);
            end
        end
        testsRun++;
        if (word_done !== 1'b1 || pout !== 8'hFF) begin
            testsFailed++;
            $display("[TB] FAIL midreset_word: got wd=%b pout=%h expected 1 FF", word_done, pout);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        applyStimulus(1'b1, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, 1'b1, (i < 12) ? 2'b01 : 2'b10, 8'h00,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            if (word_done === 1'b1) pulses++;
            expVal = sbQ.pop_front();
            obsVal = {pout, shift_cnt, word_done, sout_r, sout_l};
            testsRun++;
            if (obsVal !== expVal) begin
                testsFailed++;
                $display("[TB] FAIL b2b_shift%0d: got %h expected %h", i, obsVal, expVal);
            end
        end
        testsRun++;
        if (pulses != 3) begin
            testsFailed++;
            $display("[TB] FAIL b2b_pulses: got %0d expected 3", pulses);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0),
                          2'($urandom_range(0, 3)), 8'($urandom()),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
            expVal = sbQ.pop_front();
            obsVal = {pout, shift_cnt, word_done, sout_r, sout_l};
            testsRun++;
            if (obsVal !== expVal) begin
                testsFailed++;
                $display("[TB] FAIL random%0d: got %h expected %h", i, obsVal, expVal);
            end
        end
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate();
        applyStimulus(1'b1, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
        void'(sbQ.pop_front());
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b1);
            expVal = sbQ.pop_front();
            obsVal = {pout, shift_cnt, word_done, sout_r, sout_l};
            testsRun++;
            if (obsVal !== expVal) begin
                testsFailed++;
                $display("[TB] FAIL rotate_step%0d: got %h expected %h", i, obsVal, expVal);
            end
            if (i == 0) begin
                testsRun++;
                if (pout !== 8'h03) begin
                    testsFailed++;
                    $display("[TB] FAIL rotate_first: got %h expected 03", pout);
                end
            end
        end
        testsRun++;
        if (pout !== 8'h81 || word_done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rotate_word: got pout=%h wd=%b expected 81 1", pout, word_done);
        end
    endtask
`endif

    // Run every scenario in sequence, then print the summary.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        mPout       = '0;
        mCnt        = '0;
        mWd         = 1'b0;
        rst_n       = 1'b0;
        en          = 1'b0;
        mode        = 2'b00;
        pin         = '0;
        sin_r       = 1'b0;
        sin_l       = 1'b0;
        rot         = 1'b0;
        #1;
        test_reset();
        test_load();
        test_sipo();
        test_pause_mix();
        test_reset_midword();
        test_back_to_back();
`ifdef USR_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
